idli_sqi_ctrl_m: RTL and testbench

- SQI (quad-SPI) memory controller that produces the instruction and data stream the decode stage consumes.
- Accepts a 16b word-address read or write request and drives the external serial SRAM pins: chip select, 4b SIO bus and SCK gate.
- Read data is returned as a 16b nibble-array word alongside the 2b sync counter, so downstream blocks latch the word when the counter is all ones and the word is valid.
- Sequential mode: after one request the controller streams consecutive words until the requester drops its request.

---
 rtl/idli_sqi_ctrl_m.sv | 119 +++++++++++
 tb/tb_idli_sqi_ctrl_m.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/idli_sqi_ctrl_m.sv
// idli_sqi_ctrl_m: quad-SPI SRAM controller streaming sequential 16b words.
module idli_sqi_ctrl_m #(
  parameter logic [7:0] RD_CMD        = 8'h03,
  parameter logic [7:0] WR_CMD        = 8'h02,
  parameter int         ADDR_NIBBLES  = 6,
  parameter int         DUMMY_NIBBLES = 2
) (
  input  logic        i_sqi_gck,
  input  logic        i_sqi_rst,
  input  logic        i_sqi_req,
  input  logic        i_sqi_wr,
  input  logic [15:0] i_sqi_addr,
  output logic        o_sqi_ack,
  input  logic [15:0] i_sqi_wdata,
  output logic        o_sqi_wdata_rdy,
  output logic [15:0] o_sqi_rdata,
  output logic        o_sqi_rdata_vld,
  output logic [1:0]  o_sqi_ctr,
  output logic        o_sqi_cs_n,
  output logic        o_sqi_sck_en,
  output logic [3:0]  o_sqi_sio,
  output logic        o_sqi_sio_oe,
  input  logic [3:0]  i_sqi_sio
);
  localparam int AW = 4 * ADDR_NIBBLES;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA} state_t;
  state_t      state_q, state_d;
  logic [2:0]  ph_q, ph_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [7:0]  cmd;
  logic [AW-1:0] baddr;
  logic [1:0]  ctr;
  assign cmd   = wr_q ? WR_CMD : RD_CMD;
  assign baddr = AW'({addr_q, 1'b0});
  assign ctr   = ph_q[1:0];
  always_comb begin
    state_d         = state_q;
    ph_d            = ph_q + 3'd1;
    wr_d            = wr_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    rdata_d         = rdata_q;
    o_sqi_ack       = 1'b0;
    o_sqi_wdata_rdy = 1'b0;
    o_sqi_rdata     = rdata_q;
    o_sqi_rdata_vld = 1'b0;
    o_sqi_ctr       = 2'd0;
    o_sqi_cs_n      = 1'b0;
    o_sqi_sck_en    = 1'b1;
    o_sqi_sio       = 4'h0;
    o_sqi_sio_oe    = 1'b0;
    case (state_q)
      IDLE: begin
        o_sqi_cs_n   = 1'b1;
        o_sqi_sck_en = 1'b0;
        o_sqi_ack    = i_sqi_req;
        ph_d         = 3'd0;
        state_d      = i_sqi_req ? CMD : IDLE;
        wr_d         = i_sqi_req ? i_sqi_wr : wr_q;
        addr_d       = i_sqi_req ? i_sqi_addr : addr_q;
      end
      CMD: begin
        o_sqi_sio_oe = 1'b1;
        o_sqi_sio    = ph_q[0] ? cmd[3:0] : cmd[7:4];
        ph_d         = ph_q[0] ? 3'd0 : 3'd1;
        state_d      = ph_q[0] ? ADDR : CMD;
      end
      ADDR: begin
        o_sqi_sio_oe = 1'b1;
        o_sqi_sio    = 4'(baddr >> (4 * (ADDR_NIBBLES - 1 - int'(ph_q))));
        if (ph_q == 3'(ADDR_NIBBLES - 1)) begin
          ph_d            = 3'd0;
          state_d         = wr_q ? DATA : DUMMY;
          o_sqi_wdata_rdy = wr_q;
        end
      end
      DUMMY: begin
        if (ph_q == 3'(DUMMY_NIBBLES - 1)) begin
          ph_d    = 3'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        o_sqi_ctr    = ctr;
        o_sqi_sio_oe = wr_q;
        o_sqi_sio    = wr_q ? wdata_q[{ctr, 2'b00} +: 4] : 4'h0;
        ph_d         = {1'b0, ctr + 2'd1};
        if (!wr_q) rdata_d[{ctr, 2'b00} +: 4] = i_sqi_sio;
        // Last nibble of a word: the top nibble bypasses the flops so the word is complete now.
        if (&ctr) begin
          o_sqi_rdata_vld = !wr_q;
          o_sqi_rdata     = wr_q ? rdata_q : {i_sqi_sio, rdata_q[11:0]};
          o_sqi_wdata_rdy = wr_q & i_sqi_req;
          state_d         = i_sqi_req ? DATA : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (o_sqi_wdata_rdy) wdata_d = i_sqi_wdata;
  end
  always_ff @(posedge i_sqi_gck or posedge i_sqi_rst) begin
    if (i_sqi_rst) begin
      state_q <= IDLE;
      ph_q    <= 3'd0;
      wr_q    <= 1'b0;
      addr_q  <= 16'h0;
      wdata_q <= 16'h0;
      rdata_q <= 16'h0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// tb_idli_sqi_ctrl_m: randomized transfers checked cycle by cycle against a protocol-level model.
module tb_idli_sqi_ctrl_m;
  logic        clk = 1'b0, rst = 1'b1, req = 1'b0, wr = 1'b0;
  logic [15:0] addr = 16'h0, wdata = 16'h0;
  logic [3:0]  sio_i = 4'h0;
  logic        ack, rdy, vld, cs_n, sck_en, oe;
  logic [15:0] rdata;
  logic [1:0]  ctr;
  logic [3:0]  sio;
  int vectors = 0, miscompares = 0;
  logic [15:0] last_rx;

  idli_sqi_ctrl_m dut (
    .i_sqi_gck(clk), .i_sqi_rst(rst), .i_sqi_req(req), .i_sqi_wr(wr), .i_sqi_addr(addr),
    .o_sqi_ack(ack), .i_sqi_wdata(wdata), .o_sqi_wdata_rdy(rdy), .o_sqi_rdata(rdata),
    .o_sqi_rdata_vld(vld), .o_sqi_ctr(ctr), .o_sqi_cs_n(cs_n), .o_sqi_sck_en(sck_en),
    .o_sqi_sio(sio), .o_sqi_sio_oe(oe), .i_sqi_sio(sio_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      req = 1'b0; wr = 1'($urandom); addr = 16'($urandom); wdata = 16'($urandom); sio_i = 4'($urandom);
      @(negedge clk);
      check("idle_cs_n", cs_n, 1);
      check("idle_sck_en", sck_en, 0);
      check("idle_oe", oe, 0);
      check("idle_ack", ack, 0);
      check("idle_rdy", rdy, 0);
      check("idle_vld", vld, 0);
      check("idle_ctr", ctr, 0);
      check("idle_sio", sio, 0);
      @(posedge clk); #1;
    end
  endtask

  // One transaction of n words; k=0 is the IDLE cycle in which the request is made.
  task automatic xfer(input bit w, input logic [15:0] a, input int n, input logic [16:0] fix);
    int h = w ? 8 : 10;
    int last_k = h + 4 * n;
    int lo = (n >= 2) ? h + 4 * (n - 1) + 1 : 1;
    int drop_k = $urandom_range(last_k, lo);
    int ba = int'(a) * 2;
    int cmd = w ? 8'h02 : 8'h03;
    int j, c;
    logic [15:0] words[$];
    logic [15:0] rx = 16'h0;
    for (int k = 0; k <= last_k; k++) begin
      j = k - h - 1;
      c = (k > h) ? j % 4 : 0;
      req = (k < drop_k);
      wr = (k == 0) ? w : 1'($urandom);
      addr = (k == 0) ? a : 16'($urandom);
      wdata = (fix[16] && w && k == 8) ? fix[15:0] : 16'($urandom);
      sio_i = (fix[16] && !w && k > h) ? fix[4*c +: 4] : 4'($urandom);
      @(negedge clk);
      if (k == 0) begin
        check("req_ack", ack, 1);
        check("req_cs_n", cs_n, 1);
        check("req_sck_en", sck_en, 0);
        check("req_oe", oe, 0);
      end else begin
        check("xfer_cs_n", cs_n, 0);
        check("xfer_sck_en", sck_en, 1);
        check("xfer_ack", ack, 0);
        if (k <= 2) begin
          check("cmd_oe", oe, 1);
          check("cmd_sio", sio, (cmd >> (4 * (2 - k))) & 15);
          check("cmd_rdy", rdy, 0);
        end else if (k <= 8) begin
          check("addr_oe", oe, 1);
          check("addr_sio", sio, (ba >> (4 * (8 - k))) & 15);
          check("addr_rdy", rdy, (w && k == 8) ? 1 : 0);
        end else if (k <= h) begin
          check("dummy_oe", oe, 0);
          check("dummy_sio", sio, 0);
          check("dummy_rdy", rdy, 0);
        end else begin
          check("data_ctr", ctr, c);
          check("data_oe", oe, w ? 1 : 0);
          check("data_vld", vld, (!w && c == 3) ? 1 : 0);
          check("data_rdy", rdy, (w && c == 3 && j / 4 < n - 1) ? 1 : 0);
          if (w) check("data_sio", sio, (int'(words[j/4]) >> (4 * c)) & 15);
          else begin
            rx[4*c +: 4] = sio_i;
            if (c == 3) check("data_rdata", rdata, rx);
          end
        end
      end
      if (w && (k == 8 || (k > h && c == 3 && j / 4 < n - 1))) words.push_back(wdata);
      @(posedge clk); #1;
    end
    if (!w) last_rx = rx;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cs_n", cs_n, 1);
    check("rst_sck_en", sck_en, 0);
    check("rst_oe", oe, 0);
    check("rst_sio", sio, 0);
    check("rst_ack", ack, 0);
    check("rst_rdy", rdy, 0);
    check("rst_vld", vld, 0);
    check("rst_rdata", rdata, 0);
    check("rst_ctr", ctr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    xfer(1'b0, 16'h1234, 1, {1'b1, 16'hDCBA});
    idle(1);
    check("rdata_hold", rdata, 16'hDCBA);
    xfer(1'b0, 16'h0000, 3, 17'h0);
    idle(2);
    check("rdata_hold3", rdata, last_rx);
    xfer(1'b1, 16'hFFFF, 1, {1'b1, 16'h4321});
    idle(1);
    xfer(1'b1, 16'($urandom), 2, 17'h0);
    xfer(1'b0, 16'($urandom), 2, 17'h0);
    xfer(1'b1, 16'($urandom), 1, 17'h0);
    idle(1);
    repeat (8) begin
      xfer(1'($urandom), 16'($urandom), $urandom_range(4, 1), 17'h0);
      if ($urandom_range(1, 0) == 1) idle($urandom_range(3, 1));
    end
    req = 1'b1; wr = 1'b1; addr = 16'($urandom);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_cs_n", cs_n, 1);
    check("abort_sck_en", sck_en, 0);
    check("abort_oe", oe, 0);
    req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    check("abort_rdata", rdata, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
